// File: rtl/audio_pkg.sv
// audio_pkg: shared filter state encoding and accumulator width helper for the audio path.
package audio_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, SUB, ADD, OUT} filter_state_e;
   function automatic int sum_width(input int data_width, input int max_log2_depth);
      return data_width + max_log2_depth;
   endfunction
endpackage

// File: rtl/sample_ring_buffer.sv
// sample_ring_buffer: window storage with write-and-advance pointer wrapping modulo 2^log2_len.
module sample_ring_buffer #(
   parameter int DataWidth = 12,
   parameter int MaxLog2Depth = 3,
   localparam int LW = $clog2(MaxLog2Depth + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        write,
   input  logic [LW-1:0]               log2_len,
   input  logic signed [DataWidth-1:0] data,
   output logic signed [DataWidth-1:0] oldest
);
   logic signed [DataWidth-1:0] mem [2**MaxLog2Depth];
   logic [MaxLog2Depth-1:0] ptr, mask;
   assign mask = ~({MaxLog2Depth{1'b1}} << log2_len);
   assign oldest = mem[ptr];
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < 2**MaxLog2Depth; i++) mem[i] <= '0;
         ptr <= '0;
      end else if (write) begin
         mem[ptr] <= data;
         ptr <= (ptr + 1'b1) & mask;
      end
   end
endmodule

// File: rtl/moving_average_filter.sv
// moving_average_filter: boxcar mean over the last 2^L samples, one output pulse per accepted input.
module moving_average_filter
   import audio_pkg::*;
#(
   parameter int DataWidth = 12,
   parameter int MaxLog2Depth = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [$clog2(MaxLog2Depth+1)-1:0]    lengthLog2,
   input  logic signed [DataWidth-1:0]          sampleIn,
   input  logic                                 sampleValidPulse,
   output logic signed [DataWidth-1:0]          sampleOut,
   output logic                                 sampleOutValidPulse,
   output logic                                 busy,
   output logic                                 overrunFlag
);
   localparam int LW = $clog2(MaxLog2Depth + 1);
   localparam int SW = sum_width(DataWidth, MaxLog2Depth);
   filter_state_e state;
   logic [LW-1:0] leff, cur_l;
   logic signed [SW-1:0] sum;
   logic signed [DataWidth-1:0] latched, oldest;
   assign leff = lengthLog2 > LW'(MaxLog2Depth) ? LW'(MaxLog2Depth) : lengthLog2;
   assign busy = state != IDLE;
   sample_ring_buffer #(.DataWidth(DataWidth), .MaxLog2Depth(MaxLog2Depth)) ring (
      .clk(clk),
      .reset(reset),
      .clear(state == CLEAR),
      .write(state == ADD),
      .log2_len(cur_l),
      .data(latched),
      .oldest(oldest)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sum <= '0;
         cur_l <= '0;
         latched <= '0;
         sampleOut <= '0;
         sampleOutValidPulse <= 1'b0;
         overrunFlag <= 1'b0;
      end else begin
         sampleOutValidPulse <= 1'b0;
         // a pending window change outranks a simultaneous sample, which is lost
         if (sampleValidPulse && (state != IDLE || leff != cur_l)) overrunFlag <= 1'b1;
         case (state)
            IDLE:
               if (leff != cur_l) state <= CLEAR;
               else if (sampleValidPulse) begin
                  latched <= sampleIn;
                  state <= SUB;
               end
            CLEAR: begin
               sum <= '0;
               cur_l <= leff;
               state <= IDLE;
            end
            SUB: begin
               sum <= sum - SW'(oldest);
               state <= ADD;
            end
            ADD: begin
               sum <= sum + SW'(latched);
               state <= OUT;
            end
            OUT: begin
               sampleOut <= DataWidth'(sum >>> cur_l);
               sampleOutValidPulse <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_moving_average_filter.sv
// tb_moving_average_filter: directed vectors with hand-computed means, checked by immediate assertions.
module tb_moving_average_filter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] lengthLog2 = '0;
   logic signed [11:0] sampleIn = '0;
   logic sampleValidPulse = 1'b0;
   logic signed [11:0] sampleOut;
   logic sampleOutValidPulse, busy, overrunFlag;
   int checks = 0;
   int errors = 0;

   moving_average_filter dut (
      .clk(clk),
      .reset(reset),
      .lengthLog2(lengthLog2),
      .sampleIn(sampleIn),
      .sampleValidPulse(sampleValidPulse),
      .sampleOut(sampleOut),
      .sampleOutValidPulse(sampleOutValidPulse),
      .busy(busy),
      .overrunFlag(overrunFlag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic signed [11:0] v, input logic signed [31:0] exp, input string tag);
      @(posedge clk); #1;
      sampleIn = v;
      sampleValidPulse = 1'b1;
      @(posedge clk); #1;
      sampleValidPulse = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk({tag, "_early_valid"}, sampleOutValidPulse, 0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, sampleOutValidPulse, 1);
      chk({tag, "_out"}, sampleOut, exp);
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, sampleOutValidPulse, 0);
   endtask

   task automatic set_len(input logic [1:0] l, input string tag);
      @(posedge clk); #1;
      lengthLog2 = l;
      @(posedge clk); #1;
      chk({tag, "_clear_busy"}, busy, 1);
      @(posedge clk); #1;
      chk({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", sampleOut, 0);
      chk("rst_valid", sampleOutValidPulse, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrunFlag, 0);
      reset = 1'b0;
      send(12'sd100, 100, "bypass0");
      send(-12'sd5, -5, "bypass1");
      set_len(2'd2, "len2");
      for (int i = 1; i <= 4; i++) send(12'sd400, 100 * i, "ramp");
      set_len(2'd3, "len3");
      for (int i = 1; i <= 8; i++) send(12'sd800, 100 * i, "fill");
      for (int i = 7; i >= 0; i--) send(12'sd0, 100 * i, "drain");
      set_len(2'd1, "len1");
      send(-12'sd1, -1, "neg0");
      send(12'sd0, -1, "neg1");
      send(12'sd0, 0, "neg2");
      set_len(2'd2, "relen2");
      for (int i = 1; i <= 4; i++) send(12'sd400, 100 * i, "refill");
      set_len(2'd1, "relen1");
      send(12'sd400, 200, "after_change");
      chk("overrun_before", overrunFlag, 0);
      @(posedge clk); #1;
      sampleIn = 12'sd100;
      sampleValidPulse = 1'b1;
      @(posedge clk); #1;
      sampleValidPulse = 1'b0;
      n = 0;
      @(posedge clk); #1;
      sampleIn = 12'sd50;
      sampleValidPulse = 1'b1;
      @(posedge clk); #1;
      sampleValidPulse = 1'b0;
      if (sampleOutValidPulse) n++;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (sampleOutValidPulse) begin
            n++;
            chk("overrun_out", sampleOut, 250);
         end
      end
      chk("overrun_pulses", n, 1);
      chk("overrun_flag", overrunFlag, 1);
      @(posedge clk); #1;
      sampleIn = 12'sd300;
      sampleValidPulse = 1'b1;
      @(posedge clk); #1;
      sampleValidPulse = 1'b0;
      chk("sub_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst2_out", sampleOut, 0);
      chk("rst2_valid", sampleOutValidPulse, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_overrun", overrunFlag, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (sampleOutValidPulse) n++;
      end
      chk("rst2_pulses", n, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Boxcar moving-average filter between the I2S controller's ADC port and the DAC port. It consumes one signed sample per `sampleValidPulse` and keeps the last 2^L samples in a ring buffer with a running sum. It emits the window mean as a registered sample with a one-cycle valid pulse. The window length is selectable at run time, and any change to it flushes the filter history.

## Interface
- `DataWidth`, 12, sample width in bits, two's complement; matches the I2S controller's data width.
- `MaxLog2Depth`, 3, log2 of the ring buffer depth. The maximum window is 2^MaxLog2Depth = 8 samples.
- `clk`  in  1  system clock.
- `reset`  in  1  reset: synchronous, active-high, clock `clk`.
- `lengthLog2`  in  $clog2(MaxLog2Depth+1)  requested window exponent L.
- `sampleIn`  in  DataWidth  signed input sample; connects to adcData.
- `sampleValidPulse`  in  1  one-cycle strobe qualifying `sampleIn`; connects to adcValidPulse.
- `sampleOut`  out  DataWidth  signed mean; held stable between updates; connects to dacData.
- `sampleOutValidPulse`  out  1  one-cycle strobe, high when `sampleOut` has just updated.
- `busy`  out  1  high in any state other than IDLE.
- `overrunFlag`  out  1  sticky; set when an input pulse is dropped; cleared only by reset.

## Operation
- Effective exponent: Leff = min(lengthLog2, MaxLog2Depth). Window N = 2^Leff.
- Storage:
  - 2^MaxLog2Depth buffer entries.
  - Write pointer `ptr`, MaxLog2Depth bits, advanced modulo N.
  - Signed accumulator `sum`, DataWidth+MaxLog2Depth bits. Exact arithmetic; overflow cannot occur.
  - Latched exponent `curL`.
- States:
  - IDLE:
    - If Leff != curL, go to CLEAR. This has priority. A simultaneous `sampleValidPulse` is dropped and `overrunFlag` is set.
    - Else, if `sampleValidPulse` is high, latch `sampleIn` and go to SUB.
  - CLEAR: in one cycle, zero all buffer entries, `sum` and `ptr`; set curL <= Leff; go to IDLE.
  - SUB: sum <= sum - buffer[ptr], where buffer[ptr] is the oldest sample in the window; go to ADD.
  - ADD:
    - sum <= sum + latched sample.
    - buffer[ptr] <= latched sample.
    - ptr <= (ptr+1) mod N.
    - Go to OUT.
  - OUT: sampleOut <= sum >>> Leff, arithmetic shift, floor rounding, low DataWidth bits; pulse `sampleOutValidPulse`; go to IDLE.
- A `sampleValidPulse` arriving in SUB, ADD, OUT or CLEAR is dropped and sets `overrunFlag`. This never happens in normal use, because I2S delivers at most one sample per 128 clocks.
- Leff = 0 acts as a bypass: the output equals the input.
- Warm-up: until N samples have been seen, the empty slots contribute zero, so the output ramps.

## Timing
- Reset values:
  - Outputs: `sampleOut` = 0, `sampleOutValidPulse` = 0, `busy` = 0, `overrunFlag` = 0.
  - Internal: `sum` = 0, `ptr` = 0, all buffer entries = 0, curL = 0, state = IDLE.
- After reset, a nonzero Leff triggers a CLEAR on the first IDLE cycle.
- Latency: if `sampleValidPulse` is sampled at edge E, then SUB executes at E+1, ADD at E+2, and OUT at E+3. `sampleOut` and `sampleOutValidPulse` are both visible after edge E+3.
- `sampleOutValidPulse` is high for exactly one cycle and is deasserted at E+4.
- Minimum accepted input spacing is 4 cycles; the IDLE cycle at E+4 accepts the next pulse. A CLEAR adds 1 cycle.
- Reset asserted in any state wins: at the next edge all registers take their reset values and any in-flight sample is discarded without an output pulse.
- `lengthLog2` is sampled only in IDLE. Changes made while `busy` take effect at the next IDLE cycle.

## Structure
- Shared package `audio_pkg` holds:
  - The `filter_state_e` enum: IDLE, CLEAR, SUB, ADD, OUT.
  - The sum-width helper constant DataWidth+MaxLog2Depth.
- One natural sub-module: `sample_ring_buffer`. It holds the storage array plus `ptr`, with ports for a read of the oldest entry, write-and-advance, modulo-N wrap, and synchronous clear. The FSM, accumulator and output register stay in the top level.

## Test plan
- Bypass: L=0, inputs 100 then -5 → outputs 100 then -5; each pulse arrives exactly 3 edges after its input pulse.
- Warm-up ramp: L=2, four inputs of 400 → outputs 100, 200, 300, 400.
- Window slide and wrap:
  - L=3, eight inputs of 800 followed by eight inputs of 0.
  - Outputs 100…800, then 700, 600, …, 0.
  - `ptr` wraps twice.
- Floor rounding of negatives: L=1, inputs -1, 0, 0 → outputs -1, -1, 0.
- Length change: L=2, fill with 400, then set L=1 → one CLEAR cycle occurs (`busy` high). Next input 400 → output 200.
- Overrun and reset:
  - Two input pulses 2 cycles apart → exactly one output pulse, and `overrunFlag` = 1.
  - Reset asserted at SUB → no output pulse; all outputs return to 0 and `overrunFlag` = 0.
